adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 105 ++++++++++
 tb/tb_adder_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two requesters share one 4-bit signed adder through an IDLE/ADD/RESP FSM.
// Grant to response takes 2 cycles; requesters see ready=0 until the result is taken.

module simple_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] output_y,
  output logic       overflow
);
  assign output_y = a + b;
  // Overflow when both operands share a sign that the wrapped sum does not.
  assign overflow = (a[3] == b[3]) && (output_y[3] != a[3]);
endmodule

module adder_arbiter #(
  parameter int unsigned RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_y,
  output logic       rsp_overflow,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] op_a, op_b;
  logic       op_id;
  logic       last_id;
  logic       grant_id;
  logic       accept;
  logic [3:0] sum_y;
  logic       sum_ovf;

  simple_adder u_adder (
    .a        (op_a),
    .b        (op_b),
    .output_y (sum_y),
    .overflow (sum_ovf)
  );

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid)
      grant_id = (RR_EN != 0) ? ~last_id : 1'b0;
    else
      grant_id = req1_valid;
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_id      <= 1'b1;
      op_a         <= 4'd0;
      op_b         <= 4'd0;
      op_id        <= 1'b0;
      rsp_y        <= 4'd0;
      rsp_overflow <= 1'b0;
      rsp_id       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a  <= grant_id ? req1_a : req0_a;
        op_b  <= grant_id ? req1_b : req0_b;
        op_id <= grant_id;
      end
      if (state == ADD) begin
        rsp_y        <= sum_y;
        rsp_overflow <= sum_ovf;
        rsp_id       <= op_id;
      end
      // Fairness follows completed responses, not grants.
      if (state == RESP && rsp_ready)
        last_id <= rsp_id;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a cycle model predicts grants and results,
// and every response is popped from the expected queue while it is presented.

module tb_adder_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_overflow, busy;
  logic [3:0] rsp_y;

  int total = 0;
  int bad   = 0;

  typedef enum {M_IDLE, M_ADD, M_RESP} mstate_t;
  mstate_t     mstate = M_IDLE;
  logic        mlast  = 1'b1;
  bit          known  = 1'b0;
  bit          exp_zero = 1'b0;
  logic [5:0]  expq[$];

  always #5 clk = ~clk;

  adder_arbiter #(.RR_EN(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_y        (rsp_y),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected {id, overflow, y} from full-range integer arithmetic.
  function automatic logic [5:0] model(input logic id, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, s;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    s   = sa + sb;
    ovf = (s > 7) || (s < -8);
    return {id, ovf, s[3:0]};
  endfunction

  always @(negedge clk) begin
    logic e0, e1;
    if (!rst_n) begin
      chk("rdy0_rst", {7'd0, req0_ready}, 8'd0);
      chk("rdy1_rst", {7'd0, req1_ready}, 8'd0);
      mstate   = M_IDLE;
      mlast    = 1'b1;
      expq.delete();
      exp_zero = 1'b1;
      known    = 1'b1;
    end else if (known) begin
      e0 = (mstate == M_IDLE) && req0_valid && (!req1_valid || mlast);
      e1 = (mstate == M_IDLE) && req1_valid && !e0;
      chk("rdy0", {7'd0, req0_ready}, {7'd0, e0});
      chk("rdy1", {7'd0, req1_ready}, {7'd0, e1});
      chk("busy", {7'd0, busy}, {7'd0, mstate != M_IDLE});
      chk("rsp_valid", {7'd0, rsp_valid}, {7'd0, mstate == M_RESP});
      if (exp_zero)
        chk("rst_out", {2'd0, rsp_id, rsp_overflow, rsp_y}, 8'd0);
      case (mstate)
        M_IDLE: if (e0 || e1) begin
          expq.push_back(e1 ? model(1'b1, req1_a, req1_b) : model(1'b0, req0_a, req0_b));
          mstate = M_ADD;
        end
        M_ADD: begin
          mstate   = M_RESP;
          exp_zero = 1'b0;
        end
        default: begin
          if (expq.size() == 0) begin
            chk("rsp_unexpected", 8'd1, 8'd0);
          end else begin
            chk("rsp", {2'd0, rsp_id, rsp_overflow, rsp_y}, {2'd0, expq[0]});
            if (rsp_ready) begin
              mlast  = expq[0][5];
              void'(expq.pop_front());
              mstate = M_IDLE;
            end
          end
        end
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input logic r, input logic [3:0] a, input logic [3:0] b);
    bit got = 1'b0;
    if (r) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else   begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = r ? req1_ready : req0_ready;
      @(posedge clk);
      #1;
    end
    if (!got) chk("req_timeout", 8'd0, 8'd1);
    if (r) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  initial begin
    bit h0, h1;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    do_req(1'b0, 4'd3, 4'd2);
    cyc(3);
    do_req(1'b1, 4'd7, 4'd1);
    do_req(1'b1, 4'h8, 4'hF);
    do_req(1'b1, 4'h8, 4'd7);
    cyc(3);

    // Both requesters held valid; operands change only after their handshake.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 4'(($urandom_range(0, 15))); req0_b = 4'(($urandom_range(0, 15)));
    req1_a = 4'(($urandom_range(0, 15))); req1_b = 4'(($urandom_range(0, 15)));
    repeat (18) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (h0) begin req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15)); end
      if (h1) begin req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15)); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(4);

    // Held response, plus a requester that gives up before being granted.
    rsp_ready = 1'b0;
    do_req(1'b1, 4'd5, 4'd6);
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
    cyc(2);
    req0_valid = 1'b0;
    cyc(4);
    rsp_ready = 1'b1;
    cyc(4);

    // Reset asserted while the operation is in ADD.
    do_req(1'b0, 4'd6, 4'd6);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(5);

    for (int r = 0; r < 2; r++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          do_req(r[0], a[3:0], b[3:0]);
    cyc(5);

    chk("drain", 8'(expq.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
